// File: rtl/if_id_fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, IF/ID register and FETCH/MISS tracking.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module if_id_fetch_stage #(
    parameter int unsigned         ADDR_W    = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pc_write_i,
    input  logic               if_id_write_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               imem_ready_i,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc4_o,
    output logic               if_id_valid_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        stall_cycles_o,
    output logic [31:0]        miss_cycles_o,
    output logic [31:0]        flush_count_o,
`endif
    output logic               fetch_busy_o
);

    typedef enum logic [0:0] {StFetch, StMiss} state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;
    logic               valid_q, valid_d;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // MISS with imem_ready=1 is handled exactly like FETCH; the state only drives fetch_busy_o.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            state_d = StFetch;
            pc_d    = branch_target_i;
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (!imem_ready_i) begin
            state_d = StMiss;
            if (if_id_write_i) begin
                instr_d = NOP_INSTR;
                pc4_d   = '0;
                valid_d = 1'b0;
            end
        end else begin
            state_d = StFetch;
            if (pc_write_i) begin
                pc_d = pc_plus4;
            end
            if (if_id_write_i) begin
                instr_d = imem_instr_i;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr_o   = pc_q;
    assign if_id_instr_o = instr_q;
    assign if_id_pc4_o   = pc4_q;
    assign if_id_valid_o = valid_q;
    assign fetch_busy_o  = (state_q == StMiss);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] miss_q, miss_d;
    logic [31:0] flushc_q, flushc_d;

    // Saturating counters: hold at all-ones rather than wrapping.
    always_comb begin
        stall_d  = stall_q;
        miss_d   = miss_q;
        flushc_d = flushc_q;
        if (!flush_i && !pc_write_i && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (!flush_i && !imem_ready_i && (miss_q != 32'hFFFF_FFFF)) begin
            miss_d = miss_q + 32'd1;
        end
        if (flush_i && (flushc_q != 32'hFFFF_FFFF)) begin
            flushc_d = flushc_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q  <= '0;
            miss_q   <= '0;
            flushc_q <= '0;
        end else begin
            stall_q  <= stall_d;
            miss_q   <= miss_d;
            flushc_q <= flushc_d;
        end
    end

    assign stall_cycles_o = stall_q;
    assign miss_cycles_o  = miss_q;
    assign flush_count_o  = flushc_q;
`endif

endmodule
